// File: rtl/axi4_lite_reg_ctrl_if.sv
// ============================================================================
// Module      : axi4_lite_reg_ctrl_if
// Description : AXI4-Lite slave bus bundle for axi4_lite_reg_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface axi4_lite_reg_ctrl_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 12
);
    logic [AXI_ADDR_WIDTH-1:0] S_AWADDR;
    logic                      S_AWVALID;
    logic                      S_AWREADY;
    logic [DATA_WIDTH-1:0]     S_WDATA;
    logic [DATA_WIDTH/8-1:0]   S_WSTRB;
    logic                      S_WVALID;
    logic                      S_WREADY;
    logic [1:0]                S_BRESP;
    logic                      S_BVALID;
    logic                      S_BREADY;
    logic [AXI_ADDR_WIDTH-1:0] S_ARADDR;
    logic                      S_ARVALID;
    logic                      S_ARREADY;
    logic [DATA_WIDTH-1:0]     S_RDATA;
    logic [1:0]                S_RRESP;
    logic                      S_RVALID;
    logic                      S_RREADY;

    modport slave (
        input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
               S_ARADDR, S_ARVALID, S_RREADY,
        output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
               S_ARREADY, S_RDATA, S_RRESP, S_RVALID
    );

    modport master (
        output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
               S_ARADDR, S_ARVALID, S_RREADY,
        input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
               S_ARREADY, S_RDATA, S_RRESP, S_RVALID
    );
endinterface

`default_nettype wire

// File: rtl/axi4_lite_reg_ctrl.sv
// ============================================================================
// Module      : axi4_lite_reg_ctrl
// Description : AXI4-Lite slave sequencing a single-port register file with
//               round-robin write/read arbitration. Optional range checking
//               with SLVERR via macro AXI4_LITE_REG_CTRL_SLVERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module axi4_lite_reg_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int NUM_REGS       = 16
) (
    input  wire logic                          CLK,
    input  wire logic                          RST_N,
    axi4_lite_reg_ctrl_if.slave                s_axi,
    output logic [$clog2(NUM_REGS)-1:0]        REG_ADDR,
    output logic [DATA_WIDTH-1:0]              REG_WDATA,
    output logic                               REG_WEN,
    input  wire logic [DATA_WIDTH-1:0]         REG_RDATA
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int LSB   = $clog2(DATA_WIDTH / 8);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_BRESP = 3'd2,
        ST_RD    = 3'd3,
        ST_RRESP = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_last_wr;
    logic                  r_bvalid;
    logic                  r_rvalid;
    logic [1:0]            r_bresp;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_wr_req;
    logic                  w_rd_req;
    logic [IDX_W-1:0]      w_aw_idx;
    logic [IDX_W-1:0]      w_ar_idx;
    logic                  w_aw_err;
    logic                  w_ar_err;
    logic                  w_unused;

    assign w_wr_req = s_axi.S_AWVALID && s_axi.S_WVALID;
    assign w_rd_req = s_axi.S_ARVALID;
    assign w_aw_idx = s_axi.S_AWADDR[LSB +: IDX_W];
    assign w_ar_idx = s_axi.S_ARADDR[LSB +: IDX_W];

`ifdef AXI4_LITE_REG_CTRL_SLVERR_EN
    localparam logic [IDX_W:0] c_NUM_REGS = NUM_REGS[IDX_W:0];
    assign w_aw_err = ({1'b0, w_aw_idx} >= c_NUM_REGS);
    assign w_ar_err = ({1'b0, w_ar_idx} >= c_NUM_REGS);
`else
    assign w_aw_err = 1'b0;
    assign w_ar_err = 1'b0;
`endif

    // Byte strobes and address bits outside the index field carry no meaning here.
    assign w_unused = ^{s_axi.S_WSTRB, s_axi.S_AWADDR, s_axi.S_ARADDR};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_last_wr <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_rresp   <= c_RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Write wins unless the previous grant went to a write.
                    if (w_wr_req && (!w_rd_req || !r_last_wr)) begin
                        r_state   <= ST_WR;
                        r_last_wr <= 1'b1;
                    end else if (w_rd_req) begin
                        r_state   <= ST_RD;
                        r_last_wr <= 1'b0;
                    end
                end
                ST_WR: begin
                    r_bresp  <= w_aw_err ? c_RESP_SLVERR : c_RESP_OKAY;
                    r_bvalid <= 1'b1;
                    r_state  <= ST_BRESP;
                end
                ST_BRESP: begin
                    if (s_axi.S_BREADY) begin
                        r_bvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    r_rdata  <= w_ar_err ? '0 : REG_RDATA;
                    r_rresp  <= w_ar_err ? c_RESP_SLVERR : c_RESP_OKAY;
                    r_rvalid <= 1'b1;
                    r_state  <= ST_RRESP;
                end
                ST_RRESP: begin
                    if (s_axi.S_RREADY) begin
                        r_rvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axi.S_AWREADY = (r_state == ST_WR);
    assign s_axi.S_WREADY  = (r_state == ST_WR);
    assign s_axi.S_ARREADY = (r_state == ST_RD);
    assign s_axi.S_BVALID  = r_bvalid;
    assign s_axi.S_BRESP   = r_bresp;
    assign s_axi.S_RVALID  = r_rvalid;
    assign s_axi.S_RRESP   = r_rresp;
    assign s_axi.S_RDATA   = r_rdata;

    always_comb begin
        REG_ADDR  = '0;
        REG_WDATA = '0;
        REG_WEN   = 1'b0;
        if (r_state == ST_WR) begin
            REG_ADDR  = w_aw_idx;
            REG_WDATA = s_axi.S_WDATA;
            REG_WEN   = !w_aw_err;
        end else if (r_state == ST_RD) begin
            REG_ADDR  = w_ar_idx;
        end
    end

endmodule

`default_nettype wire

// File: doc/axi4_lite_reg_ctrl.md
# axi4_lite_reg_ctrl

AXI4-Lite slave front end that sequences the single-port register-file SRAM (`sram_reg`) shared by the read and write channels. It accepts AW/W and AR transactions and arbitrates between them round-robin. Each transaction becomes a single-cycle register-file access, and the controller returns B/R responses with full VALID/READY handshaking. It sits between the system interconnect and the generated register file inside the `axi4_lite_reg` wrapper.

## Interface
- `DATA_WIDTH`, 32: AXI and register data width; must be 32 or 64.
- `AXI_ADDR_WIDTH`, 12: AXI byte-address width.
- `NUM_REGS`, 16: register count; ≥2.
- Derived localparams:
  - `IDX_W` = $clog2(`NUM_REGS`).
  - `LSB` = $clog2(`DATA_WIDTH`/8).
- `CLK` in 1: the block's single clock; all logic on its rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- AXI write address: `S_AWADDR` in `AXI_ADDR_WIDTH`; `S_AWVALID` in 1; `S_AWREADY` out 1.
- AXI write data: `S_WDATA` in `DATA_WIDTH`; `S_WSTRB` in `DATA_WIDTH`/8 (ignored; writes are full-word); `S_WVALID` in 1; `S_WREADY` out 1.
- AXI write response: `S_BRESP` out 2; `S_BVALID` out 1; `S_BREADY` in 1.
- AXI read address: `S_ARADDR` in `AXI_ADDR_WIDTH`; `S_ARVALID` in 1; `S_ARREADY` out 1.
- AXI read data: `S_RDATA` out `DATA_WIDTH`; `S_RRESP` out 2; `S_RVALID` out 1; `S_RREADY` in 1.
- Register-file side:
  - `REG_ADDR` out `IDX_W`: register index.
  - `REG_WDATA` out `DATA_WIDTH`.
  - `REG_WEN` out 1.
  - `REG_RDATA` in `DATA_WIDTH`: combinational read of `REG_ADDR`.

## Operation
- FSM states: IDLE, WR, BRESP, RD, RRESP.
- Register index = AxADDR[`LSB` +: `IDX_W`]. Lower address bits are ignored.
- IDLE:
  - Write request = `S_AWVALID` && `S_WVALID`. AW without W, or W without AW, is not a request.
  - Only write requested -> WR. Only `S_ARVALID` -> RD.
  - Both requested -> round-robin on flag `last_wr`: `last_wr`=1 grants read, else write. The flag updates on every grant.
- WR (one cycle):
  - `S_AWREADY`=`S_WREADY`=1.
  - `REG_ADDR`=index(`S_AWADDR`), `REG_WDATA`=`S_WDATA`, `REG_WEN`=1.
  - Latch response code -> BRESP.
- BRESP: `S_BVALID`=1 and `S_BRESP` held stable until `S_BREADY`=1, then -> IDLE.
- RD (one cycle):
  - `S_ARREADY`=1, `REG_ADDR`=index(`S_ARADDR`).
  - Capture `REG_RDATA` into the `S_RDATA` register -> RRESP.
- RRESP: `S_RVALID`=1, with `S_RDATA`/`S_RRESP` stable until `S_RREADY`=1, then -> IDLE.
- One outstanding transaction total. No READY is asserted outside WR/RD.
- AXI requires VALIDs to stay asserted until READY. WR/RD therefore sample address and data directly from the bus.
- `REG_WEN` is 0 in every state except WR. `REG_ADDR`/`REG_WDATA` drive 0 outside WR/RD.
- Reset (any state, mid-transaction included):
  - State -> IDLE, `last_wr`=0.
  - All READY/VALID = 0, `S_RDATA`=0, `S_BRESP`=`S_RRESP`=2'b00.
  - An interrupted transaction is dropped; no response is issued.

## Timing
- Write: request seen in IDLE at cycle 0 -> WR at cycle 1 (AW/W handshake plus `REG_WEN` pulse) -> `S_BVALID` from cycle 2.
- Read: `S_ARVALID` at cycle 0 -> RD at cycle 1 -> `S_RVALID` with data from cycle 2.
- Throughput: with BREADY/RREADY held high, one transaction every 3 cycles.
- Back-to-back write then read to the same index: the read returns the new data. The write completes in WR before the read's RD cycle.
- `S_BRESP`, `S_RRESP`, `S_RDATA`, `S_BVALID` and `S_RVALID` are registered. READYs, `REG_*` and `REG_WEN` are decoded from state.

## Configuration
- `AXI4_LITE_REG_CTRL_SLVERR_EN` defined:
  - Any access with index ≥ `NUM_REGS` responds SLVERR (2'b10).
  - Such writes suppress `REG_WEN`; `REG_WEN` stays 0 in WR.
  - Such reads return `S_RDATA`=0.
- Undefined: no range check. All responses are OKAY and the index uses only the low `IDX_W` bits, so out-of-range addresses alias.

## Test plan
- Reset then write 0xDEADBEEF to byte addr 0x08 (DATA_WIDTH=32) -> `REG_WEN` pulses once with `REG_ADDR`=2 in cycle 1. `S_BVALID` from cycle 2 with `S_BRESP`=OKAY.
- Read addr 0x08 with `S_RREADY` low for 4 cycles -> `S_RVALID` high from cycle 2, `S_RDATA`=0xDEADBEEF held stable until the handshake.
- `S_AWVALID`, `S_WVALID` and `S_ARVALID` all asserted in the same cycle for 4 consecutive transactions -> grant order W, R, W, R.
- `S_AWVALID` high with `S_WVALID` low for 5 cycles -> no READY, no `REG_WEN`. `S_WVALID` rises -> write completes normally.
- Assert `RST_N`=0 while in BRESP with `S_BREADY` low -> `S_BVALID`=0 immediately. After release, the next read transaction completes normally.
- With `AXI4_LITE_REG_CTRL_SLVERR_EN` and `NUM_REGS`=12, write to addr 0x30 -> `REG_WEN` stays 0, `S_BRESP`=2'b10. Without the macro, the same write hits index 12 mod 16 = 12 with OKAY.
